// File: rtl/wb_master_ctrl.sv
`timescale 1ns/1ps
// Wishbone classic single-transfer initiator.
// One command in, one bus cycle out, one response back; bounded by TIMEOUT.
module wb_master_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [7:0]  cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  input  logic [3:0]  cmd_sel_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        rsp_timeout_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [7:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        busy_o
);

  localparam int unsigned CW =
    (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] TO_LAST =
    (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          cyc_n, we_n, rdy_n;
  logic [7:0]    adr_n;
  logic [31:0]   dat_n, rdat_n;
  logic [3:0]    sel_n;
  logic          vld_n, err_n, to_n;
  logic          done;

  assign wb_stb_o = wb_cyc_o;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cyc_n   = wb_cyc_o;
    we_n    = wb_we_o;
    adr_n   = wb_adr_o;
    dat_n   = wb_dat_o;
    sel_n   = wb_sel_o;
    rdy_n   = cmd_ready_o;
    vld_n   = rsp_valid_o;
    err_n   = rsp_err_o;
    to_n    = rsp_timeout_o;
    rdat_n  = rsp_dat_o;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_valid_i) begin
          we_n    = cmd_we_i;
          adr_n   = {cmd_adr_i[7:2], 2'b00};
          dat_n   = cmd_dat_i;
          sel_n   = cmd_sel_i;
          cnt_n   = '0;
          cyc_n   = 1'b1;
          rdy_n   = 1'b0;
          state_n = BUS;
        end
      end
      BUS: begin
        // err has priority over a simultaneous ack
        if (wb_err_i) begin
          err_n  = 1'b1;
          rdat_n = '0;
          done   = 1'b1;
        end else if (wb_ack_i) begin
          err_n  = 1'b0;
          rdat_n = wb_we_o ? '0 : wb_dat_i;
          done   = 1'b1;
        end else if (TIMEOUT != 0 && cnt == TO_LAST) begin
          to_n   = 1'b1;
          rdat_n = '0;
          done   = 1'b1;
        end else if (cnt != CNT_MAX) begin
          cnt_n = cnt + 1'b1;
        end
        if (done) begin
          cyc_n   = 1'b0;
          vld_n   = 1'b1;
          state_n = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          vld_n   = 1'b0;
          err_n   = 1'b0;
          to_n    = 1'b0;
          rdy_n   = 1'b1;
          state_n = IDLE;
        end
      end
      default: begin
        cyc_n   = 1'b0;
        rdy_n   = 1'b1;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state         <= IDLE;
      cnt           <= '0;
      wb_cyc_o      <= 1'b0;
      wb_we_o       <= 1'b0;
      wb_adr_o      <= '0;
      wb_dat_o      <= '0;
      wb_sel_o      <= '0;
      cmd_ready_o   <= 1'b1;
      rsp_valid_o   <= 1'b0;
      rsp_err_o     <= 1'b0;
      rsp_timeout_o <= 1'b0;
      rsp_dat_o     <= '0;
      busy_o        <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      wb_cyc_o      <= cyc_n;
      wb_we_o       <= we_n;
      wb_adr_o      <= adr_n;
      wb_dat_o      <= dat_n;
      wb_sel_o      <= sel_n;
      cmd_ready_o   <= rdy_n;
      rsp_valid_o   <= vld_n;
      rsp_err_o     <= err_n;
      rsp_timeout_o <= to_n;
      rsp_dat_o     <= rdat_n;
      busy_o        <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_wb_master_ctrl.sv
`timescale 1ns/1ps
// Bench for wb_master_ctrl: directed cases then random commands
// against a transaction-level expectation model and a simple slave.
module tb_wb_master_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [7:0]  cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_dat;
  logic        wb_cyc, wb_stb, wb_we, wb_ack, wb_err, busy;
  logic [7:0]  wb_adr;
  logic [31:0] wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel;

  always #5 clk = ~clk;

  wb_master_ctrl #(.TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_we_i(cmd_we), .cmd_adr_i(cmd_adr),
    .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err),
    .rsp_timeout_o(rsp_timeout),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we),
    .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack), .wb_err_i(wb_err),
    .busy_o(busy)
  );

  // slave: terminates in the (lat+1)-th strobe cycle
  typedef enum int {K_ACK, K_ERR, K_BOTH, K_SILENT} kind_t;
  kind_t       s_kind = K_ACK;
  int          s_lat = 0;
  logic [31:0] s_rdata = '0;
  logic        spur = 1'b0;
  int          stb_cnt;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) stb_cnt <= 0;
    else stb_cnt <= wb_stb ? stb_cnt + 1 : 0;

  assign wb_ack = spur || (wb_stb && stb_cnt == s_lat &&
                  (s_kind == K_ACK || s_kind == K_BOTH));
  assign wb_err = wb_stb && stb_cnt == s_lat &&
                  (s_kind == K_ERR || s_kind == K_BOTH);
  assign wb_dat_i = s_rdata;

  int checks = 0, passed = 0, fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic we, input logic [7:0] adr,
                     input logic [31:0] dat, input logic [3:0] sel,
                     input kind_t kind, input int lat,
                     input logic [31:0] rdata, input int bp,
                     input logic hold, input logic spur_en,
                     input string tag);
    int n_exp, n, k, w;
    logic [31:0] dexp;
    logic eexp, texp, ok;
    if (kind == K_SILENT || lat >= TO) begin
      n_exp = TO; texp = 1'b1; eexp = 1'b0; dexp = '0;
    end else begin
      n_exp = lat + 1; texp = 1'b0;
      eexp = (kind != K_ACK);
      dexp = (!eexp && !we) ? rdata : 32'h0;
    end
    s_kind = kind; s_lat = lat; s_rdata = rdata;
    cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    cmd_valid = 1'b1; rsp_ready = 1'b0;
    w = 0;
    while (!cmd_ready && w < 20) begin @(negedge clk); w++; end
    chk({tag, " accept"}, 32'(w < 20), 1);
    @(posedge clk);
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
    chk({tag, " adr"}, {24'h0, wb_adr}, {24'h0, adr[7:2], 2'b00});
    chk({tag, " wdat"}, wb_dat_o, dat);
    chk({tag, " we/sel/rdy/busy"}, {wb_we, wb_sel, cmd_ready, busy},
        {we, sel, 1'b0, 1'b1});
    n = 0; k = 1; ok = 1'b1;
    while (!rsp_valid && k < 40) begin
      if (wb_stb) n++;
      if (wb_cyc !== wb_stb || cmd_ready) ok = 1'b0;
      @(negedge clk);
      k++;
    end
    chk({tag, " rsp_valid"}, rsp_valid, 1);
    chk({tag, " stb cycles"}, n, n_exp);
    chk({tag, " latency"}, k, n_exp + 1);
    chk({tag, " bus sane"}, ok, 1);
    chk({tag, " rdat"}, rsp_dat, dexp);
    chk({tag, " err/to/cyc"}, {rsp_err, rsp_timeout, wb_cyc},
        {eexp, texp, 1'b0});
    for (int i = 0; i < bp; i++) begin
      spur = spur_en && (i == 0);
      @(negedge clk);
      spur = 1'b0;
      chk({tag, " hold flags"},
          {rsp_valid, rsp_err, rsp_timeout, cmd_ready, wb_stb, busy},
          {1'b1, eexp, texp, 1'b0, 1'b0, 1'b1});
      chk({tag, " hold rdat"}, rsp_dat, dexp);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, " after hs"},
        {rsp_valid, rsp_err, rsp_timeout, cmd_ready, busy, wb_stb},
        {5'b00010, 1'b0});
    chk({tag, " wb held"}, {wb_we, wb_adr[7:0], wb_sel},
        {we, adr[7:2], 2'b00, sel});
  endtask

  initial begin
    kind_t kk;
    logic  bad;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 8'h00;
    cmd_dat = 32'h0; cmd_sel = 4'hF; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset flags",
        {wb_cyc, wb_stb, wb_we, busy, rsp_valid, rsp_err, rsp_timeout},
        0);
    chk("reset adr/sel", {20'h0, wb_adr, wb_sel}, 0);
    chk("reset wdat", wb_dat_o, 0);
    chk("reset rdat", rsp_dat, 0);
    rst_n = 1'b1;
    #1;
    chk("release ready", cmd_ready, 1);
    chk("release cyc", wb_cyc, 0);

    run(1'b0, 8'h00, 32'h0, 4'hF, K_ACK, 0, 32'h1234_5678,
        0, 1'b0, 1'b0, "rd_comb");
    run(1'b1, 8'h07, 32'hA5A5_0001, 4'hF, K_ACK, 1, 32'hDEAD_BEEF,
        0, 1'b0, 1'b0, "wr_reg");
    run(1'b0, 8'h10, 32'h0, 4'h3, K_BOTH, 0, 32'hCAFE_F00D,
        1, 1'b0, 1'b0, "ack_err");
    run(1'b1, 8'h22, 32'h5555_AAAA, 4'h1, K_SILENT, 0, 32'h0,
        3, 1'b0, 1'b1, "timeout");

    spur = 1'b1;
    repeat (2) @(negedge clk);
    spur = 1'b0;
    chk("spurious idle", {wb_cyc, rsp_valid, busy, cmd_ready}, 4'b0001);

    run(1'b0, 8'h35, 32'h0, 4'hC, K_ACK, 2, 32'h0BAD_F00D,
        10, 1'b1, 1'b0, "bp");
    run(1'b0, 8'h3B, 32'h0, 4'hF, K_ERR, 1, 32'h1111_2222,
        0, 1'b0, 1'b0, "after_bp");

    for (int i = 0; i < 25; i++) begin
      kk = kind_t'($urandom_range(0, 3));
      run(1'($urandom_range(0, 1)), 8'($urandom), $urandom,
          4'($urandom), kk, int'($urandom_range(0, 5)), $urandom,
          int'($urandom_range(0, 3)), 1'b0, 1'b0, "rand");
    end

    s_kind = K_SILENT;
    cmd_we = 1'b0; cmd_adr = 8'h44; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("mid reset cyc before", wb_cyc, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid reset abort", {wb_cyc, wb_stb, busy, rsp_valid}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid || wb_cyc) bad = 1'b1;
    end
    chk("no rsp after reset", bad, 0);
    chk("ready after reset", cmd_ready, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
